// File: rtl/ct_idu_vreg_pkg.sv
// Shared types for the vector-register writeback arbiter.
//   PregW / DataW : physical vreg index and writeback data widths
//   wb_entry_t    : one buffered writeback {preg, data}
//   prod_e        : producer index (0: VFPU pipe6, 1: VFPU pipe7, 2: LSU pipe3)
package ct_idu_vreg_pkg;

  localparam int unsigned PregW   = 7;
  localparam int unsigned DataW   = 64;
  localparam int unsigned NumProd = 3;
  localparam int unsigned NumPort = 2;

  typedef struct packed {
    logic [PregW-1:0] preg;
    logic [DataW-1:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    ProdPipe6 = 2'd0,
    ProdPipe7 = 2'd1,
    ProdPipe3 = 2'd2
  } prod_e;

  // Producer visited at scan step k when the round-robin pointer is ptr (mod 3).
  function automatic prod_e rr_idx(input prod_e ptr, input logic [1:0] k);
    logic [2:0] s;
    s = {1'b0, ptr} + {1'b0, k};
    case (s)
      3'd0, 3'd3: return ProdPipe6;
      3'd1, 3'd4: return ProdPipe7;
      default:    return ProdPipe3;
    endcase
  endfunction

  // Successor of a producer index, mod 3.
  function automatic prod_e rr_next(input prod_e p);
    case (p)
      ProdPipe6: return ProdPipe7;
      ProdPipe7: return ProdPipe3;
      default:   return ProdPipe6;
    endcase
  endfunction

endpackage

// File: rtl/ct_idu_vreg_wb_fifo.sv
// Per-producer writeback FIFO.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   push_i/wdata_i : write tail (caller guarantees !full_o)
//   pop_i          : drop head (caller guarantees !empty_o)
//   head_o         : current head entry
//   full_o/empty_o : registered occupancy flags
//   count_o        : registered occupancy
// Depth must be a power of two so the pointers wrap naturally.
module ct_idu_vreg_wb_fifo
  import ct_idu_vreg_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    push_i,
  input  wb_entry_t               wdata_i,
  input  logic                    pop_i,
  output wb_entry_t               head_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [$clog2(Depth):0]  count_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth) + 1;

  wb_entry_t       mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: contents are only observed when count_q says so.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/ct_idu_rf_vreg_wb_arb.sv
// Vector-register writeback arbiter: three producers (0: VFPU pipe6, 1: VFPU pipe7, 2: LSU pipe3),
// each buffered in its own FIFO, drained round-robin onto two regfile write ports.
//   forever_cpuclk, cpurst_b      : clock, asynchronous active-low reset
//   req<i>_vld/preg/data_i        : producer writeback; req<i>_rdy_o = FIFO i not full
//   rf_wb_stall_i                 : blocks all grants, pops and bypasses
//   wbp<j>_vld/preg/data_o        : write port j (combinational from FIFO heads + grant)
//   arb_idle_o                    : all FIFOs empty
// Optional macro CT_VREG_WB_ARB_BYPASS_EN: an empty-FIFO producer may go straight to a free port in
// its push cycle, arbitrated after FIFO heads in the same rr order.
module ct_idu_rf_vreg_wb_arb
  import ct_idu_vreg_pkg::*;
#(
  parameter int unsigned FifoDepth = 2
) (
  input  logic             forever_cpuclk,
  input  logic             cpurst_b,
  input  logic             req0_vld_i,
  input  logic [PregW-1:0] req0_preg_i,
  input  logic [DataW-1:0] req0_data_i,
  output logic             req0_rdy_o,
  input  logic             req1_vld_i,
  input  logic [PregW-1:0] req1_preg_i,
  input  logic [DataW-1:0] req1_data_i,
  output logic             req1_rdy_o,
  input  logic             req2_vld_i,
  input  logic [PregW-1:0] req2_preg_i,
  input  logic [DataW-1:0] req2_data_i,
  output logic             req2_rdy_o,
  input  logic             rf_wb_stall_i,
  output logic             wbp0_vld_o,
  output logic [PregW-1:0] wbp0_preg_o,
  output logic [DataW-1:0] wbp0_data_o,
  output logic             wbp1_vld_o,
  output logic [PregW-1:0] wbp1_preg_o,
  output logic [DataW-1:0] wbp1_data_o,
  output logic             arb_idle_o
);

  localparam int unsigned CntW = $clog2(FifoDepth) + 1;

  logic [NumProd-1:0] req_vld, req_rdy, fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [NumProd-1:0] fifo_elig, byp_cand, byp_taken;
  wb_entry_t          req_ent  [NumProd];
  wb_entry_t          fifo_head[NumProd];
  logic [CntW-1:0]    fifo_cnt [NumProd];

  logic [NumPort-1:0] g_vld, g_byp;
  prod_e              g_idx [NumPort];
  prod_e              cand;
  wb_entry_t          port_ent[NumPort];
  prod_e              rr_ptr_q, rr_ptr_d;

  assign req_vld    = {req2_vld_i, req1_vld_i, req0_vld_i};
  assign req_ent[0] = '{preg: req0_preg_i, data: req0_data_i};
  assign req_ent[1] = '{preg: req1_preg_i, data: req1_data_i};
  assign req_ent[2] = '{preg: req2_preg_i, data: req2_data_i};

  // rdy comes from registered occupancy only, so a same-cycle pop never raises it.
  assign req_rdy   = ~fifo_full;
  assign fifo_elig = ~fifo_empty & {NumProd{~rf_wb_stall_i}};
  // An empty FIFO cannot have been granted, so emptiness alone rules out double grants.
  assign byp_cand  = req_vld & fifo_empty & {NumProd{~rf_wb_stall_i}};

  for (genvar i = 0; i < NumProd; i++) begin : g_fifo
    ct_idu_vreg_wb_fifo #(
      .Depth (FifoDepth)
    ) u_fifo (
      .clk_i   (forever_cpuclk),
      .rst_ni  (cpurst_b),
      .push_i  (fifo_push[i]),
      .wdata_i (req_ent[i]),
      .pop_i   (fifo_pop[i]),
      .head_o  (fifo_head[i]),
      .full_o  (fifo_full[i]),
      .empty_o (fifo_empty[i]),
      .count_o (fifo_cnt[i])
    );

    assert property (@(posedge forever_cpuclk) disable iff (!cpurst_b)
                     !(req_vld[i] && !req_rdy[i]))
      else $error("producer %0d pushed while not ready", i);
  end

  // Round-robin scan: first hit -> port0, second -> port1.
  always_comb begin
    g_vld    = '0;
    g_byp    = '0;
    g_idx[0] = ProdPipe6;
    g_idx[1] = ProdPipe6;
    cand     = ProdPipe6;
    for (int k = 0; k < NumProd; k++) begin
      cand = rr_idx(rr_ptr_q, 2'(k));
      if (fifo_elig[cand]) begin
        if (!g_vld[0]) begin
          g_vld[0] = 1'b1;
          g_idx[0] = cand;
        end else if (!g_vld[1]) begin
          g_vld[1] = 1'b1;
          g_idx[1] = cand;
        end
      end
    end
`ifdef CT_VREG_WB_ARB_BYPASS_EN
    for (int k = 0; k < NumProd; k++) begin
      cand = rr_idx(rr_ptr_q, 2'(k));
      if (byp_cand[cand]) begin
        if (!g_vld[0]) begin
          g_vld[0] = 1'b1;
          g_byp[0] = 1'b1;
          g_idx[0] = cand;
        end else if (!g_vld[1]) begin
          g_vld[1] = 1'b1;
          g_byp[1] = 1'b1;
          g_idx[1] = cand;
        end
      end
    end
`endif
  end

  always_comb begin
    for (int i = 0; i < NumProd; i++) begin
      fifo_pop[i]  = (g_vld[0] && !g_byp[0] && (g_idx[0] == 2'(i))) ||
                     (g_vld[1] && !g_byp[1] && (g_idx[1] == 2'(i)));
      byp_taken[i] = (g_vld[0] && g_byp[0] && (g_idx[0] == 2'(i))) ||
                     (g_vld[1] && g_byp[1] && (g_idx[1] == 2'(i)));
      fifo_push[i] = req_vld[i] && req_rdy[i] && !byp_taken[i];
    end
    for (int j = 0; j < NumPort; j++) begin
      port_ent[j] = g_byp[j] ? req_ent[g_idx[j]] : fifo_head[g_idx[j]];
    end
  end

  // Port1 is only ever filled after port0, so the last grant sits on port1 when it is valid.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (g_vld[1])      rr_ptr_d = rr_next(g_idx[1]);
    else if (g_vld[0]) rr_ptr_d = rr_next(g_idx[0]);
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) rr_ptr_q <= ProdPipe6;
    else           rr_ptr_q <= rr_ptr_d;
  end

  assign req0_rdy_o  = req_rdy[0];
  assign req1_rdy_o  = req_rdy[1];
  assign req2_rdy_o  = req_rdy[2];
  assign wbp0_vld_o  = g_vld[0];
  assign wbp0_preg_o = port_ent[0].preg;
  assign wbp0_data_o = port_ent[0].data;
  assign wbp1_vld_o  = g_vld[1];
  assign wbp1_preg_o = port_ent[1].preg;
  assign wbp1_data_o = port_ent[1].data;
  assign arb_idle_o  = (fifo_cnt[0] == '0) && (fifo_cnt[1] == '0) && (fifo_cnt[2] == '0);

endmodule

// File: tb/tb_ct_idu_rf_vreg_wb_arb.sv
// Directed bench for ct_idu_rf_vreg_wb_arb (FIFO depth 2). Inputs change 1ns after the rising
// edge; outputs are sampled 1ns later, well away from the edge.
module tb_ct_idu_rf_vreg_wb_arb;

  logic        clk, rst_n;
  logic        r0_vld, r1_vld, r2_vld, stall;
  logic [6:0]  r0_preg, r1_preg, r2_preg;
  logic [63:0] r0_data, r1_data, r2_data;
  logic        r0_rdy, r1_rdy, r2_rdy;
  logic        p0_vld, p1_vld, idle;
  logic [6:0]  p0_preg, p1_preg;
  logic [63:0] p0_data, p1_data;
  int          n_pass, n_total;

  ct_idu_rf_vreg_wb_arb dut (
    .forever_cpuclk (clk),
    .cpurst_b       (rst_n),
    .req0_vld_i     (r0_vld),
    .req0_preg_i    (r0_preg),
    .req0_data_i    (r0_data),
    .req0_rdy_o     (r0_rdy),
    .req1_vld_i     (r1_vld),
    .req1_preg_i    (r1_preg),
    .req1_data_i    (r1_data),
    .req1_rdy_o     (r1_rdy),
    .req2_vld_i     (r2_vld),
    .req2_preg_i    (r2_preg),
    .req2_data_i    (r2_data),
    .req2_rdy_o     (r2_rdy),
    .rf_wb_stall_i  (stall),
    .wbp0_vld_o     (p0_vld),
    .wbp0_preg_o    (p0_preg),
    .wbp0_data_o    (p0_data),
    .wbp1_vld_o     (p1_vld),
    .wbp1_preg_o    (p1_preg),
    .wbp1_data_o    (p1_data),
    .arb_idle_o     (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    r0_vld = 1'b0;
    r1_vld = 1'b0;
    r2_vld = 1'b0;
  endtask

  task automatic drive(input int i, input logic [6:0] p, input logic [63:0] d);
    case (i)
      0: begin r0_vld = 1'b1; r0_preg = p; r0_data = d; end
      1: begin r1_vld = 1'b1; r1_preg = p; r1_data = d; end
      default: begin r2_vld = 1'b1; r2_preg = p; r2_data = d; end
    endcase
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    n_total++;
    if ({r2_rdy, r1_rdy, r0_rdy, p0_vld, p1_vld, idle} !== 6'b111_001)
      $display("FAIL reset_state got rdy=%b v0=%b v1=%b idle=%b exp rdy=111 v0=0 v1=0 idle=1",
               {r2_rdy, r1_rdy, r0_rdy}, p0_vld, p1_vld, idle);
    else n_pass++;
    rst_n = 1'b1;
    tick();
    stall = 1'b1;
    drive(0, 7'd3, 64'h33);
    drive(1, 7'd4, 64'h44);
    tick();
    clear_req();
    #1;
    n_total++;
    if ({idle, r1_rdy, r0_rdy} !== 3'b011)
      $display("FAIL queued_state got idle=%b rdy1=%b rdy0=%b exp 0 1 1", idle, r1_rdy, r0_rdy);
    else n_pass++;
    stall = 1'b0;
    #1;
    n_total++;
    if ({p0_vld, p0_preg, p0_data} !== {1'b1, 7'd3, 64'h33})
      $display("FAIL queued_head got v=%b p=%0d d=%h exp v=1 p=3 d=33", p0_vld, p0_preg, p0_data);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({p0_vld, p1_vld, idle, r2_rdy, r1_rdy, r0_rdy} !== 6'b001_111)
      $display("FAIL reset_midtraffic got v0=%b v1=%b idle=%b rdy=%b exp 0 0 1 111",
               p0_vld, p1_vld, idle, {r2_rdy, r1_rdy, r0_rdy});
    else n_pass++;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_latency();
    drive(0, 7'd5, 64'hA5);
    #1;
`ifdef CT_VREG_WB_ARB_BYPASS_EN
    n_total++;
    if ({p0_vld, p0_preg, p0_data} !== {1'b1, 7'd5, 64'hA5})
      $display("FAIL lat_push_cycle got v=%b p=%0d d=%h exp v=1 p=5 d=a5", p0_vld, p0_preg, p0_data);
    else n_pass++;
`else
    n_total++;
    if (p0_vld !== 1'b0)
      $display("FAIL lat_push_cycle got v0=%b exp 0", p0_vld);
    else n_pass++;
`endif
    tick();
    clear_req();
    #1;
`ifdef CT_VREG_WB_ARB_BYPASS_EN
    n_total++;
    if (p0_vld !== 1'b0) $display("FAIL lat_next_cycle got v0=%b exp 0", p0_vld);
    else n_pass++;
`else
    n_total++;
    if ({p0_vld, p0_preg, p0_data} !== {1'b1, 7'd5, 64'hA5})
      $display("FAIL lat_next_cycle got v=%b p=%0d d=%h exp v=1 p=5 d=a5", p0_vld, p0_preg, p0_data);
    else n_pass++;
`endif
    n_total++;
    if (p1_vld !== 1'b0) $display("FAIL lat_port1_idle got v1=%b exp 0", p1_vld);
    else n_pass++;
    tick();
    n_total++;
    if (idle !== 1'b1) $display("FAIL lat_drained got idle=%b exp 1", idle);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    pulse_reset();
    stall = 1'b1;
    drive(0, 7'd10, 64'h100);
    drive(1, 7'd11, 64'h101);
    drive(2, 7'd12, 64'h102);
    tick();
    clear_req();
    #1;
    n_total++;
    if ({p0_vld, p1_vld} !== 2'b00) $display("FAIL rr_stalled got v=%b%b exp 00", p0_vld, p1_vld);
    else n_pass++;
    stall = 1'b0;
    #1;
    n_total++;
    if ({p0_vld, p0_preg, p0_data, p1_vld, p1_preg, p1_data} !==
        {1'b1, 7'd10, 64'h100, 1'b1, 7'd11, 64'h101})
      $display("FAIL rr_cycle1 got p0=%b/%0d/%h p1=%b/%0d/%h exp 1/10/100 1/11/101",
               p0_vld, p0_preg, p0_data, p1_vld, p1_preg, p1_data);
    else n_pass++;
    tick();
    n_total++;
    if ({p0_vld, p0_preg, p0_data, p1_vld} !== {1'b1, 7'd12, 64'h102, 1'b0})
      $display("FAIL rr_cycle2 got p0=%b/%0d/%h v1=%b exp 1/12/102 0",
               p0_vld, p0_preg, p0_data, p1_vld);
    else n_pass++;
    tick();
    n_total++;
    if (idle !== 1'b1) $display("FAIL rr_drained got idle=%b exp 1", idle);
    else n_pass++;
  endtask

  task automatic test_full_backpressure();
    stall = 1'b1;
    drive(1, 7'd20, 64'h20);
    #1;
    n_total++;
    if (r1_rdy !== 1'b1) $display("FAIL bp_rdy_push1 got %b exp 1", r1_rdy);
    else n_pass++;
    tick();
    drive(1, 7'd21, 64'h21);
    #1;
    n_total++;
    if (r1_rdy !== 1'b1) $display("FAIL bp_rdy_push2 got %b exp 1", r1_rdy);
    else n_pass++;
    tick();
    clear_req();
    #1;
    n_total++;
    if ({r2_rdy, r1_rdy, r0_rdy, p0_vld} !== 4'b101_0)
      $display("FAIL bp_full got rdy=%b v0=%b exp rdy=101 v0=0", {r2_rdy, r1_rdy, r0_rdy}, p0_vld);
    else n_pass++;
    stall = 1'b0;
    #1;
    n_total++;
    if ({r1_rdy, p0_vld, p0_preg, p0_data, p1_vld} !== {1'b0, 1'b1, 7'd20, 64'h20, 1'b0})
      $display("FAIL bp_drain1 got rdy1=%b p0=%b/%0d/%h v1=%b exp 0 1/20/20 0",
               r1_rdy, p0_vld, p0_preg, p0_data, p1_vld);
    else n_pass++;
    tick();
    n_total++;
    if ({r1_rdy, p0_vld, p0_preg, p0_data} !== {1'b1, 1'b1, 7'd21, 64'h21})
      $display("FAIL bp_drain2 got rdy1=%b p0=%b/%0d/%h exp 1 1/21/21",
               r1_rdy, p0_vld, p0_preg, p0_data);
    else n_pass++;
    tick();
    n_total++;
    if (idle !== 1'b1) $display("FAIL bp_drained got idle=%b exp 1", idle);
    else n_pass++;
  endtask

  task automatic test_rr_wrap();
    // A lone req1 grant leaves rr_ptr at 2.
    stall = 1'b1;
    drive(1, 7'd30, 64'h30);
    tick();
    clear_req();
    stall = 1'b0;
    #1;
    n_total++;
    if ({p0_vld, p0_preg} !== {1'b1, 7'd30}) $display("FAIL wrap_setup got %b/%0d exp 1/30", p0_vld, p0_preg);
    else n_pass++;
    tick();
    stall = 1'b1;
    drive(0, 7'd40, 64'h40);
    drive(2, 7'd42, 64'h42);
    tick();
    clear_req();
    stall = 1'b0;
    #1;
    n_total++;
    if ({p0_vld, p0_preg, p0_data, p1_vld, p1_preg, p1_data} !==
        {1'b1, 7'd42, 64'h42, 1'b1, 7'd40, 64'h40})
      $display("FAIL wrap_grant got p0=%b/%0d/%h p1=%b/%0d/%h exp 1/42/42 1/40/40",
               p0_vld, p0_preg, p0_data, p1_vld, p1_preg, p1_data);
    else n_pass++;
    tick();
    // rr_ptr should now be 1: req1 first, then req2.
    stall = 1'b1;
    drive(0, 7'd50, 64'h50);
    drive(1, 7'd51, 64'h51);
    drive(2, 7'd52, 64'h52);
    tick();
    clear_req();
    stall = 1'b0;
    #1;
    n_total++;
    if ({p0_vld, p0_preg, p1_vld, p1_preg} !== {1'b1, 7'd51, 1'b1, 7'd52})
      $display("FAIL wrap_ptr1 got p0=%b/%0d p1=%b/%0d exp 1/51 1/52", p0_vld, p0_preg, p1_vld, p1_preg);
    else n_pass++;
    tick();
    n_total++;
    if ({p0_vld, p0_preg, p1_vld} !== {1'b1, 7'd50, 1'b0})
      $display("FAIL wrap_last got p0=%b/%0d v1=%b exp 1/50 0", p0_vld, p0_preg, p1_vld);
    else n_pass++;
    tick();
  endtask

`ifdef CT_VREG_WB_ARB_BYPASS_EN
  task automatic test_bypass();
    pulse_reset();
    drive(2, 7'd9, 64'h99);
    #1;
    n_total++;
    if ({p0_vld, p0_preg, p0_data, p1_vld, idle} !== {1'b1, 7'd9, 64'h99, 1'b0, 1'b1})
      $display("FAIL byp_same_cycle got p0=%b/%0d/%h v1=%b idle=%b exp 1/9/99 0 1",
               p0_vld, p0_preg, p0_data, p1_vld, idle);
    else n_pass++;
    tick();
    clear_req();
    #1;
    n_total++;
    if ({p0_vld, idle} !== 2'b01) $display("FAIL byp_not_queued got v0=%b idle=%b exp 0 1", p0_vld, idle);
    else n_pass++;
    stall = 1'b1;
    drive(2, 7'd8, 64'h88);
    #1;
    n_total++;
    if (p0_vld !== 1'b0) $display("FAIL byp_stalled got v0=%b exp 0", p0_vld);
    else n_pass++;
    tick();
    clear_req();
    stall = 1'b0;
    #1;
    n_total++;
    if ({idle, p0_vld, p0_preg} !== {1'b0, 1'b1, 7'd8})
      $display("FAIL byp_stall_queued got idle=%b p0=%b/%0d exp 0 1/8", idle, p0_vld, p0_preg);
    else n_pass++;
    tick();
  endtask
`endif

  initial begin
    n_pass  = 0;
    n_total = 0;
    stall   = 1'b0;
    r0_preg = '0; r1_preg = '0; r2_preg = '0;
    r0_data = '0; r1_data = '0; r2_data = '0;
    clear_req();
    test_reset();
    test_single_latency();
    test_round_robin();
    test_full_backpressure();
    test_rr_wrap();
`ifdef CT_VREG_WB_ARB_BYPASS_EN
    test_bypass();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
